// File: rtl/image_pkg.sv
// Shared framing constants and FSM encoding for the image TX framer and RX parser.
package image_pkg;
    localparam int HDR_BYTES = 4;
    localparam int DIM_W     = 16;
    localparam int CNT_W     = 32;
    localparam logic [1:0] LAST_HDR = 2'(HDR_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, SEND_HDR, WAIT_HDR, SEND_PIX, WAIT_PIX, DONE
    } state_t;

    // Header is big-endian height followed by big-endian width
    function automatic logic [7:0] hdr_byte(input logic [DIM_W-1:0] h,
                                            input logic [DIM_W-1:0] w,
                                            input logic [1:0]       idx);
        case (idx)
            2'd0:    return h[15:8];
            2'd1:    return h[7:0];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction
endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; push when full and pop when empty are ignored.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/image_tx_framer.sv
// Frames one image for the UART transmitter: 4-byte H/W header, then H*W buffered pixel bytes.
module image_tx_framer
    import image_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [DIM_W-1:0] height,
    input  logic [DIM_W-1:0] width,
    input  logic [7:0]       pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_done,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow
);
    state_t           state;
    logic [DIM_W-1:0] h_q, w_q;
    logic [CNT_W-1:0] total, pix_in_cnt, pix_out_cnt;
    logic [1:0]       hdr_idx;
    logic             push, pop, pix_turn, fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;

    assign pix_ready = busy && !fifo_full && (pix_in_cnt < total);
    assign push      = pix_valid && pix_ready;

    // A pixel slot opens while waiting in SEND_PIX or right on the tx_done that
    // frees the transmitter; popping on that edge keeps tx_done->tx_valid at one cycle.
    assign pix_turn = (state == SEND_PIX) ||
                      (tx_done && state == WAIT_PIX && pix_out_cnt != total) ||
                      (tx_done && state == WAIT_HDR && hdr_idx == LAST_HDR && total != '0);
    assign pop      = pix_turn && !fifo_empty;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (pix_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            h_q         <= '0;
            w_q         <= '0;
            total       <= '0;
            pix_in_cnt  <= '0;
            pix_out_cnt <= '0;
            hdr_idx     <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            if (push) pix_in_cnt <= pix_in_cnt + 1'b1;
            if (busy && pix_valid && !pix_ready) overflow <= 1'b1;

            if (pop) begin
                tx_valid    <= 1'b1;
                tx_data     <= fifo_dout;
                pix_out_cnt <= pix_out_cnt + 1'b1;
                state       <= WAIT_PIX;
            end else if (pix_turn) begin
                state <= SEND_PIX;
            end

            case (state)
                IDLE: if (start) begin
                    h_q         <= height;
                    w_q         <= width;
                    total       <= {16'd0, height} * {16'd0, width};
                    hdr_idx     <= '0;
                    pix_in_cnt  <= '0;
                    pix_out_cnt <= '0;
                    overflow    <= 1'b0;
                    busy        <= 1'b1;
                    tx_valid    <= 1'b1;
                    tx_data     <= height[15:8];
                    state       <= SEND_HDR;
                end
                SEND_HDR: state <= WAIT_HDR;
                WAIT_HDR: if (tx_done) begin
                    if (hdr_idx != LAST_HDR) begin
                        hdr_idx  <= hdr_idx + 2'd1;
                        tx_valid <= 1'b1;
                        tx_data  <= hdr_byte(h_q, w_q, hdr_idx + 2'd1);
                        state    <= SEND_HDR;
                    end else if (total == '0) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                SEND_PIX: ;
                WAIT_PIX: if (tx_done && pix_out_cnt == total) begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_image_tx_framer.sv
// Randomized self-checking bench for image_tx_framer against a byte-stream reference model.
module tb_image_tx_framer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] height = '0, width = '0;
    logic [7:0]  pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready, tx_valid, busy, frame_done, overflow;
    logic [7:0]  tx_data;
    logic        resp_done = 1'b0, stray_done = 1'b0;
    logic        tx_done;

    int checks = 0, errors = 0;
    int tx_delay = 3;
    int fd_cnt = 0;
    int gb, fb;
    logic [7:0] got[$], sent[$], exp_q[$];

    assign tx_done = resp_done | stray_done;

    image_tx_framer #(.FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
        .clk(clk), .rstn(rstn), .start(start), .height(height), .width(width),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_done(tx_done), .busy(busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Byte and frame_done monitor
    always @(negedge clk) begin
        if (rstn && tx_valid) got.push_back(tx_data);
        if (frame_done) fd_cnt++;
    end

    // UART transmitter stand-in: tx_done lands tx_delay cycles after tx_valid
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (!rstn) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) resp_done = 1'b1;
            end else if (tx_valid) begin
                cnt = tx_delay - 1;
                if (cnt == 0) resp_done = 1'b1;
            end
        end
    end

    // Reference: header from the dimensions, then the first nacc pixels offered
    task automatic build_exp(input logic [15:0] h, input logic [15:0] w, input int nacc);
        exp_q.delete();
        exp_q.push_back(h[15:8]); exp_q.push_back(h[7:0]);
        exp_q.push_back(w[15:8]); exp_q.push_back(w[7:0]);
        for (int i = 0; i < nacc; i++) exp_q.push_back(sent[i]);
    endtask

    task automatic reset_dut();
        rstn = 1'b0; start = 1'b0; pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the negedge of the cycle after start was accepted
    task automatic start_frame(input logic [15:0] h, input logic [15:0] w);
        @(negedge clk);
        start = 1'b1; height = h; width = w;
        gb = got.size(); fb = fd_cnt; sent.delete();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int gap, input int base);
        for (int i = 0; i < n; i++) begin
            pix_data  = (base >= 0) ? 8'(base + i) : 8'($urandom);
            pix_valid = 1'b1;
            sent.push_back(pix_data);
            @(negedge clk);
            pix_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_frame(input int max);
        for (int i = 0; i < max && fd_cnt == fb; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready got %b want 0", pix_ready); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Fixed 2x3 frame then random small frames whose pixels all fit in the FIFO
    task automatic test_basic();
        for (int it = 0; it < 4; it++) begin
            logic [15:0] h, w;
            h = (it == 0) ? 16'd2 : 16'($urandom_range(1, 4));
            w = (it == 0) ? 16'd3 : 16'($urandom_range(1, 4));
            tx_delay = (it == 0) ? 5 : $urandom_range(2, 6);
            start_frame(h, w);
            checks++; if (tx_valid !== 1'b1 || tx_data !== h[15:8] || busy !== 1'b1) begin
                errors++; $display("FAIL basic_latency it%0d got v=%b d=%h b=%b want 1 %h 1", it, tx_valid, tx_data, busy, h[15:8]);
            end
            feed(int'(h) * int'(w), 0, (it == 0) ? 16 : -1);
            wait_frame(800);
            build_exp(h, w, int'(h) * int'(w));
            checks++; if (got.size() - gb !== exp_q.size()) begin errors++; $display("FAIL basic_len it%0d got %0d want %0d", it, got.size() - gb, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
                checks++; if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte it%0d[%0d] got %h want %h", it, i, got[gb+i], exp_q[i]); end
            end
            checks++; if (fd_cnt - fb !== 1) begin errors++; $display("FAIL basic_frame_done it%0d got %0d want 1", it, fd_cnt - fb); end
            checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_flags it%0d got ovf=%b busy=%b want 0 0", it, overflow, busy); end
        end
    endtask

    // Larger frames with pixels trickling in slower than the transmitter drains
    task automatic test_stream();
        for (int it = 0; it < 2; it++) begin
            logic [15:0] h, w;
            h = 16'($urandom_range(1, 3));
            w = 16'($urandom_range(5, 13));
            tx_delay = $urandom_range(2, 5);
            start_frame(h, w);
            feed(int'(h) * int'(w), 8, -1);
            wait_frame(500);
            build_exp(h, w, int'(h) * int'(w));
            checks++; if (got.size() - gb !== exp_q.size()) begin errors++; $display("FAIL stream_len it%0d got %0d want %0d", it, got.size() - gb, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
                checks++; if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL stream_byte it%0d[%0d] got %h want %h", it, i, got[gb+i], exp_q[i]); end
            end
            checks++; if (fd_cnt - fb !== 1 || overflow !== 1'b0) begin errors++; $display("FAIL stream_end it%0d got fd=%0d ovf=%b want 1 0", it, fd_cnt - fb, overflow); end
        end
    endtask

    // Zero-pixel frames: header only
    task automatic test_zero();
        for (int it = 0; it < 2; it++) begin
            logic [15:0] h, w;
            h = (it == 0) ? 16'h0100 : 16'h0000;
            w = (it == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hffff));
            tx_delay = $urandom_range(2, 6);
            start_frame(h, w);
            wait_frame(200);
            build_exp(h, w, 0);
            checks++; if (got.size() - gb !== 4) begin errors++; $display("FAIL zero_len it%0d got %0d want 4", it, got.size() - gb); end
            for (int i = 0; i < 4 && gb + i < got.size(); i++) begin
                checks++; if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL zero_byte it%0d[%0d] got %h want %h", it, i, got[gb+i], exp_q[i]); end
            end
            checks++; if (fd_cnt - fb !== 1 || overflow !== 1'b0) begin errors++; $display("FAIL zero_end it%0d got fd=%0d ovf=%b want 1 0", it, fd_cnt - fb, overflow); end
        end
    endtask

    // Burst larger than the FIFO while the header crawls out: only DEPTH pixels survive
    task automatic test_fifo_overflow();
        tx_delay = 20;
        start_frame(16'd1, 16'd40);
        feed(40, 0, -1);
        for (int i = 0; i < 2000 && got.size() - gb < 4 + DEPTH; i++) @(negedge clk);
        repeat (200) @(negedge clk);
        build_exp(16'd1, 16'd40, DEPTH);
        checks++; if (got.size() - gb !== 4 + DEPTH) begin errors++; $display("FAIL ovf_len got %0d want %0d", got.size() - gb, 4 + DEPTH); end
        for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
            checks++; if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte[%0d] got %h want %h", i, got[gb+i], exp_q[i]); end
        end
        checks++; if (fd_cnt - fb !== 0 || busy !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_stall got fd=%0d busy=%b ovf=%b want 0 1 1", fd_cnt - fb, busy, overflow);
        end
        reset_dut();
    endtask

    // One pixel more than H*W: the extra is refused and flagged
    task automatic test_excess();
        tx_delay = 4;
        start_frame(16'd1, 16'd2);
        feed(3, 0, -1);
        wait_frame(300);
        build_exp(16'd1, 16'd2, 2);
        checks++; if (got.size() - gb !== 6) begin errors++; $display("FAIL excess_len got %0d want 6", got.size() - gb); end
        for (int i = 0; i < 6 && gb + i < got.size(); i++) begin
            checks++; if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL excess_byte[%0d] got %h want %h", i, got[gb+i], exp_q[i]); end
        end
        checks++; if (fd_cnt - fb !== 1 || overflow !== 1'b1) begin errors++; $display("FAIL excess_end got fd=%0d ovf=%b want 1 1", fd_cnt - fb, overflow); end
    endtask

    // Reset while a pixel is outstanding, then a clean frame with no stale pixels
    task automatic test_reset_mid();
        logic [15:0] h, w;
        tx_delay = 6;
        start_frame(16'd2, 16'd4);
        feed(8, 0, -1);
        for (int i = 0; i < 300 && got.size() - gb < 5; i++) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0) begin
            errors++; $display("FAIL midreset got v=%b busy=%b rdy=%b want 0 0 0", tx_valid, busy, pix_ready);
        end
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        h = 16'($urandom_range(1, 3)); w = 16'($urandom_range(1, 4));
        tx_delay = $urandom_range(2, 6);
        start_frame(h, w);
        feed(int'(h) * int'(w), 0, -1);
        wait_frame(500);
        build_exp(h, w, int'(h) * int'(w));
        checks++; if (got.size() - gb !== exp_q.size()) begin errors++; $display("FAIL midreset_len got %0d want %0d", got.size() - gb, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
            checks++; if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL midreset_byte[%0d] got %h want %h", i, got[gb+i], exp_q[i]); end
        end
        checks++; if (fd_cnt - fb !== 1) begin errors++; $display("FAIL midreset_fd got %0d want 1", fd_cnt - fb); end
    endtask

    // Stray tx_done in IDLE and a second start mid-frame must not disturb anything
    task automatic test_restart();
        tx_delay = 4;
        @(negedge clk); stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stray_idle got v=%b busy=%b want 0 0", tx_valid, busy); end
        start_frame(16'd1, 16'd2);
        feed(3, 0, -1);
        repeat (4) @(negedge clk);
        start = 1'b1; height = 16'h0505; width = 16'h0707;
        @(negedge clk);
        start = 1'b0;
        wait_frame(300);
        build_exp(16'd1, 16'd2, 2);
        checks++; if (got.size() - gb !== 6) begin errors++; $display("FAIL restart_len got %0d want 6", got.size() - gb); end
        for (int i = 0; i < 6 && gb + i < got.size(); i++) begin
            checks++; if (got[gb+i] !== exp_q[i]) begin errors++; $display("FAIL restart_byte[%0d] got %h want %h", i, got[gb+i], exp_q[i]); end
        end
        checks++; if (fd_cnt - fb !== 1 || overflow !== 1'b1) begin errors++; $display("FAIL restart_end got fd=%0d ovf=%b want 1 1", fd_cnt - fb, overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_zero();
        test_fifo_overflow();
        test_excess();
        test_reset_mid();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
